// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks a wrapping index range on the spare
// read port and streams each register value with its index and last flag.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_end_addr,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(REG_DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] end_reg;
  logic [ADDR_WIDTH-1:0] ptr_inc;
  logic                  at_end;
  logic                  hs;

  // The read port always looks at the next register to be loaded.
  assign o_rf_addr = ptr;
  assign at_end    = (ptr == end_reg);
  assign hs        = o_valid & i_ready;

  // Index advance wraps at REG_DEPTH, which need not be a power of two.
  always_comb begin
    ptr_inc = ptr + ADDR_WIDTH'(1);
    if (ptr == LAST_IDX) begin
      ptr_inc = '0;
    end
  end

  // Control FSM and the single-entry output register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      end_reg <= '0;
      o_data  <= '0;
      o_addr  <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            ptr     <= i_start_addr;
            end_reg <= i_end_addr;
            o_busy  <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (i_abort) begin
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            o_data  <= i_rf_data;
            o_addr  <= ptr;
            o_last  <= at_end;
            o_valid <= 1'b1;
            if (!at_end) begin
              ptr <= ptr_inc;
            end
            state <= STREAM;
          end
        end
        STREAM: begin
          if (i_abort) begin
            o_valid <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end else if (hs && o_last) begin
            o_valid <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end else if (hs) begin
            // Refill in the same edge as the handshake for full rate.
            o_data <= i_rf_data;
            o_addr <= ptr;
            o_last <= at_end;
            if (!at_end) begin
              ptr <= ptr_inc;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: ranges, wrap, backpressure,
// abort, busy start and asynchronous reset.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [4:0]  i_start_addr = '0;
  logic [4:0]  i_end_addr = '0;
  logic        i_abort = 1'b0;
  logic [4:0]  o_rf_addr;
  logic [31:0] i_rf_data;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic [4:0]  o_addr;
  logic        o_last;
  logic        o_busy;
  logic        o_done;

  logic [31:0] rf [32];

  int errors = 0;
  int checks = 0;

  int          got_addr [$];
  logic [31:0] got_data [$];
  logic        got_last [$];
  int          got_cyc [$];
  int          exp_addr [$];
  logic [31:0] exp_data [$];
  logic        exp_last [$];
  int          done_cyc;
  int          done_cnt;
  int          first_valid;

  always #5 clk = ~clk;

  // x0 is hard-wired to zero in the register file itself.
  assign i_rf_data = (o_rf_addr == 5'd0) ? 32'd0 : rf[o_rf_addr];

  regfile_dump_reader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .REG_DEPTH(32)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .i_start(i_start),
    .i_start_addr(i_start_addr),
    .i_end_addr(i_end_addr),
    .i_abort(i_abort),
    .o_rf_addr(o_rf_addr),
    .i_rf_data(i_rf_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data(o_data),
    .o_addr(o_addr),
    .o_last(o_last),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input int a, input logic [31:0] d,
                             input logic l);
    exp_addr.push_back(a);
    exp_data.push_back(d);
    exp_last.push_back(l);
  endtask

  // mode 0: ready always high; mode 1: ready 1,0,0 repeating plus
  // a stray start pulse while busy. abort_after: raise i_abort for one
  // cycle right after that many handshakes (0 = never).
  task automatic dump(input logic [4:0] s, input logic [4:0] e,
                      input int mode, input int abort_after);
    int          hs;
    bit          abort_next;
    bit          stalled;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    logic        h_last;
    hs = 0;
    abort_next = 0;
    stalled = 0;
    h_addr = '0;
    h_data = '0;
    h_last = 1'b0;
    got_addr.delete();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
    done_cyc = -1;
    done_cnt = 0;
    first_valid = -1;
    @(posedge clk); #1;
    i_start = 1'b1;
    i_start_addr = s;
    i_end_addr = e;
    i_ready = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      i_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      i_abort = abort_next;
      abort_next = 0;
      if (mode == 1 && cyc == 5) begin
        i_start = 1'b1;
        i_start_addr = 5'd9;
        i_end_addr = 5'd9;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      if (stalled) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_addr", o_addr, h_addr);
        chk("hold_data", o_data, h_data);
        chk("hold_last", o_last, h_last);
      end
      stalled = o_valid && !i_ready;
      h_addr = o_addr;
      h_data = o_data;
      h_last = o_last;
      if (o_valid && first_valid < 0) first_valid = cyc;
      if (o_valid && i_ready) begin
        got_addr.push_back(int'(o_addr));
        got_data.push_back(o_data);
        got_last.push_back(o_last);
        got_cyc.push_back(cyc);
        hs++;
        if (hs == abort_after) abort_next = 1;
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("valid_in_done", o_valid, 0);
        chk("busy_in_done", o_busy, 1);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("done_one_cycle", o_done, 0);
        chk("busy_after", o_busy, 0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_ready = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    if (done_cyc < 0) chk("timeout_done", 0, 1);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, got_addr.size(), exp_addr.size());
    chk({tag, "_done_cnt"}, done_cnt, 1);
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
        chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        chk($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
      end
    end
    exp_addr.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;

    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_last", o_last, 0);
    chk("rst_data", o_data, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_rf_addr", o_rf_addr, 0);
    #11 arst_n = 1'b1;

    // Basic 4-word dump at full rate.
    rf[1] = 32'h11;
    rf[2] = 32'h22;
    rf[3] = 32'h33;
    rf[4] = 32'h44;
    expect_word(1, 32'h11, 0);
    expect_word(2, 32'h22, 0);
    expect_word(3, 32'h33, 0);
    expect_word(4, 32'h44, 1);
    dump(5'd1, 5'd4, 0, 0);
    chk("t1_latency", first_valid, 1);
    if (got_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk("t1_back2back", got_cyc[i], got_cyc[0] + i);
      chk("t1_done_after_last", done_cyc, got_cyc[3] + 1);
    end
    check_words("t1");

    // Wrapping range through index 0.
    rf[30] = 32'hA;
    rf[31] = 32'hB;
    rf[0] = 32'hDEAD;
    rf[1] = 32'hC;
    expect_word(30, 32'hA, 0);
    expect_word(31, 32'hB, 0);
    expect_word(0, 32'h0, 0);
    expect_word(1, 32'hC, 1);
    dump(5'd30, 5'd1, 0, 0);
    check_words("t2");

    // Single register.
    rf[7] = 32'h77;
    expect_word(7, 32'h77, 1);
    dump(5'd7, 5'd7, 0, 0);
    check_words("t3");

    // Backpressure over 8 words with a stray start while busy.
    for (int i = 0; i < 8; i++) begin
      rf[10 + i] = 32'h100 + i;
      expect_word(10 + i, 32'h100 + i, i == 7);
    end
    rf[9] = 32'h999;
    dump(5'd10, 5'd17, 1, 0);
    check_words("t4");

    // Abort after the 2nd handshake of a 10-word dump; the word shown
    // during the abort cycle is still accepted.
    for (int i = 0; i < 10; i++) rf[5 + i] = 32'h500 + i;
    expect_word(5, 32'h500, 0);
    expect_word(6, 32'h501, 0);
    expect_word(7, 32'h502, 0);
    dump(5'd5, 5'd14, 0, 2);
    if (got_cyc.size() == 3)
      chk("t5_valid_drop", done_cyc, got_cyc[2] + 1);
    check_words("t5");

    rf[20] = 32'h2020;
    rf[21] = 32'h2121;
    expect_word(20, 32'h2020, 0);
    expect_word(21, 32'h2121, 1);
    dump(5'd20, 5'd21, 0, 0);
    check_words("t5_restart");

    // Asynchronous reset in the middle of a long dump.
    @(posedge clk); #1;
    i_start = 1'b1;
    i_start_addr = 5'd0;
    i_end_addr = 5'd31;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    chk("t6_valid", o_valid, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_done", o_done, 0);
    chk("t6_last", o_last, 0);
    chk("t6_data", o_data, 0);
    chk("t6_addr", o_addr, 0);
    chk("t6_rf_addr", o_rf_addr, 0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", o_done, 0);
      chk("t6_idle", o_busy, 0);
    end
    i_ready = 1'b0;

    rf[3] = 32'h33;
    expect_word(3, 32'h33, 1);
    dump(5'd3, 5'd3, 0, 0);
    check_words("t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug and readout engine on the spare register-file read port. It reads a contiguous, optionally wrapping, range of architectural registers. Each value is emitted as one word on a valid/ready output stream, tagged with its register index and a last flag. Typical consumers are the debug UART or a scan-out buffer. It drives the register-file read address and consumes the combinational read data.

Parameters:
DATA_WIDTH, 32, width of register data and output word
ADDR_WIDTH, 5, width of register index
REG_DEPTH, 32, number of registers; indices wrap modulo REG_DEPTH

Ports:
clk  input  1  clock, rising edge
arst_n  input  1  asynchronous active-low reset
i_start  input  1  start pulse; sampled only in IDLE
i_start_addr  input  ADDR_WIDTH  first register index, captured with i_start
i_end_addr  input  ADDR_WIDTH  last register index, inclusive, captured with i_start
i_abort  input  1  terminate dump; synchronous
o_rf_addr  output  ADDR_WIDTH  read address to register-file read port
i_rf_data  input  DATA_WIDTH  combinational read data for o_rf_addr, same cycle
o_valid  output  1  output word valid
i_ready  input  1  consumer accepts word when o_valid & i_ready
o_data  output  DATA_WIDTH  register value
o_addr  output  ADDR_WIDTH  index of o_data
o_last  output  1  o_data is the end_addr word
o_busy  output  1  high in any state except IDLE
o_done  output  1  one-cycle pulse after the last word is accepted or after an abort

Behaviour:
- Reset (arst_n=0, asynchronous): state=IDLE; ptr, end register, o_rf_addr, o_data, o_addr = 0; o_valid, o_last, o_busy, o_done = 0. Reset mid-dump discards everything; no o_done.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - i_start=1: capture start into ptr and end into end_reg; go to LOAD.
  - i_start while not IDLE is ignored.
- LOAD:
  - o_rf_addr=ptr; latch o_data<=i_rf_data, o_addr<=ptr, o_last<=(ptr==end_reg), o_valid<=1.
  - If not last, ptr advances; go to STREAM.
  - Latency: i_start at edge N gives o_valid=1 after edge N+1.
- STREAM, 1-entry output register:
  - o_rf_addr=ptr at all times.
  - On a handshake with o_last=0: reload o_data/o_addr/o_last from ptr in the same edge and advance ptr. Throughput is 1 word per cycle while i_ready=1.
  - On a handshake with o_last=1: o_valid<=0; go to DONE.
  - With o_valid=1 and i_ready=0: o_data, o_addr and o_last hold stable, ptr holds, and no word is dropped or duplicated.
- DONE: o_done=1 for one cycle; go to IDLE. o_busy=0 in IDLE only.
- ptr increment: (ptr+1) mod REG_DEPTH.
- Range rules:
  - start==end gives a single word with o_last=1.
  - start>end wraps through REG_DEPTH-1 to 0, for REG_DEPTH-start+end+1 words in total.
- Register data is sampled at its load edge; no snapshot is taken. Writes to a register before it is loaded are visible, writes after it is loaded are not.
- i_abort:
  - In LOAD or STREAM: o_valid<=0 next edge; a handshake in the same cycle still completes; go to DONE; o_done pulses.
  - In IDLE or DONE: no effect.
  - i_abort has priority over loading a new word.
- Register x0 reads as 0 through the register file; this block applies no special handling.

Test Plan:
- Preload r1..r4=0x11,0x22,0x33,0x44, i_ready=1, start=1 end=4 -> 4 words on consecutive cycles with o_addr 1,2,3,4, o_data 0x11..0x44, o_last only on addr 4, o_done one cycle later, o_busy low after.
- start=30 end=1 with r30=0xA, r31=0xB, r1=0xC -> o_addr sequence 30,31,0,1; data 0xA,0xB,0,0xC; o_last on 1.
- start=end=7 -> exactly one word with o_last=1 and o_addr=7; o_done pulses.
- Backpressure: i_ready toggles 1,0,0,1,... over 8 words -> data/addr held stable while stalled; all 8 words delivered exactly once in order.
- i_abort asserted after the 2nd handshake of a 10-word dump -> o_valid drops next cycle, o_done pulses, then IDLE; a new i_start is accepted afterwards.
- arst_n pulsed low mid-stream, and i_start pulsed while busy -> all outputs 0 immediately on reset with no o_done; the start pulse while busy has no effect on the sequence.
